// File: rtl/mac_pe_stream_if.sv
// Beat, forwarding and result bundle of one streaming MAC processing element.
// The slave side is the PE; the master side is whatever feeds and observes it.
interface mac_pe_stream_if #(
    parameter int DATA_WIDTH = 12,
    parameter int OUT_WIDTH  = 12
);
    logic                  in_valid;
    logic                  in_first;
    logic                  in_last;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] weight_in;

    logic [DATA_WIDTH-1:0] data_out;
    logic [DATA_WIDTH-1:0] weight_out;
    logic                  fwd_valid;
    logic                  fwd_first;
    logic                  fwd_last;

    logic                  out_valid;
    logic [OUT_WIDTH-1:0]  out_result;
    logic                  out_ovf;

    modport master (
        output in_valid, in_first, in_last, data_in, weight_in,
        input  data_out, weight_out, fwd_valid, fwd_first, fwd_last,
        input  out_valid, out_result, out_ovf
    );

    modport slave (
        input  in_valid, in_first, in_last, data_in, weight_in,
        output data_out, weight_out, fwd_valid, fwd_first, fwd_last,
        output out_valid, out_result, out_ovf
    );
endinterface

// File: rtl/mac_pe_stream.sv
// Streaming fixed-point MAC PE: framed dot-product with saturating accumulator,
// rounded/saturated per-vector result and registered neighbour forwarding.
module mac_pe_stream #(
    parameter int DATA_WIDTH = 12,
    parameter int FRAC_BITS  = 6,
    parameter int ACC_WIDTH  = 32,
    parameter int OUT_WIDTH  = 12,
    parameter int ROUND      = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    mac_pe_stream_if.slave bus
);
    localparam int PW  = 2 * DATA_WIDTH;
    localparam int AW1 = ACC_WIDTH + 1;

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = ~OUT_MAX;
    localparam int RND_SHIFT = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
    localparam logic signed [AW1-1:0] RND_CONST =
        (ROUND != 0 && FRAC_BITS > 0) ? (AW1'(1) << RND_SHIFT) : '0;

    // S1: input capture, doubles as the forwarding register
    logic                  s1_valid_reg;
    logic                  s1_first_reg;
    logic                  s1_last_reg;
    logic [DATA_WIDTH-1:0] s1_data_reg;
    logic [DATA_WIDTH-1:0] s1_weight_reg;

    // S2: product
    logic                        s2_valid_reg;
    logic                        s2_first_reg;
    logic                        s2_last_reg;
    logic signed [ACC_WIDTH-1:0] s2_prod_reg;

    // S3: accumulator
    logic signed [ACC_WIDTH-1:0] acc_reg;
    logic                        ovf_reg;
    logic                        s3_done_reg;

    // S4: result
    logic                 out_valid_reg;
    logic [OUT_WIDTH-1:0] out_result_reg;
    logic                 out_ovf_reg;

    logic signed [PW-1:0]        data_ext;
    logic signed [PW-1:0]        weight_ext;
    logic signed [PW-1:0]        prod_full;
    logic signed [ACC_WIDTH-1:0] prod_ext;

    logic signed [AW1-1:0]       acc_sum;
    logic                        acc_clamp;
    logic signed [ACC_WIDTH-1:0] acc_next;

    logic signed [AW1-1:0]       rnd_sum;
    logic signed [ACC_WIDTH-1:0] rnd_acc;
    logic signed [ACC_WIDTH-1:0] shifted;
    logic                        out_hi;
    logic                        out_lo;
    logic [OUT_WIDTH-1:0]        conv_result;

    // Operands widened first so the product is exact at 2*DATA_WIDTH bits.
    assign data_ext   = PW'($signed(s1_data_reg));
    assign weight_ext = PW'($signed(s1_weight_reg));
    assign prod_full  = data_ext * weight_ext;
    assign prod_ext   = ACC_WIDTH'(prod_full);

    // One guard bit detects signed overflow of the running sum.
    assign acc_sum   = AW1'(acc_reg) + AW1'(s2_prod_reg);
    assign acc_clamp = acc_sum[ACC_WIDTH] != acc_sum[ACC_WIDTH-1];
    assign acc_next  = !acc_clamp ? acc_sum[ACC_WIDTH-1:0]
                     : (acc_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX);

    assign rnd_sum = AW1'(acc_reg) + RND_CONST;
    assign rnd_acc = (rnd_sum[ACC_WIDTH] == rnd_sum[ACC_WIDTH-1]) ? rnd_sum[ACC_WIDTH-1:0]
                   : (rnd_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX);
    assign shifted = rnd_acc >>> FRAC_BITS;

    assign out_hi = shifted > OUT_MAX;
    assign out_lo = shifted < OUT_MIN;
    assign conv_result = out_hi ? OUT_MAX[OUT_WIDTH-1:0]
                       : out_lo ? OUT_MIN[OUT_WIDTH-1:0]
                       : shifted[OUT_WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            s1_first_reg  <= 1'b0;
            s1_last_reg   <= 1'b0;
            s1_data_reg   <= '0;
            s1_weight_reg <= '0;
        end else if (en) begin
            s1_valid_reg  <= bus.in_valid;
            s1_first_reg  <= bus.in_first;
            s1_last_reg   <= bus.in_last;
            s1_data_reg   <= bus.data_in;
            s1_weight_reg <= bus.weight_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_reg <= 1'b0;
            s2_first_reg <= 1'b0;
            s2_last_reg  <= 1'b0;
            s2_prod_reg  <= '0;
        end else if (en) begin
            s2_valid_reg <= s1_valid_reg;
            s2_first_reg <= s1_first_reg;
            s2_last_reg  <= s1_last_reg;
            s2_prod_reg  <= prod_ext;
        end
    end

    // A first beat restarts the vector, silently dropping any unfinished one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg     <= '0;
            ovf_reg     <= 1'b0;
            s3_done_reg <= 1'b0;
        end else if (en) begin
            s3_done_reg <= s2_valid_reg & s2_last_reg;
            if (s2_valid_reg) begin
                if (s2_first_reg) begin
                    acc_reg <= s2_prod_reg;
                    ovf_reg <= 1'b0;
                end else begin
                    acc_reg <= acc_next;
                    ovf_reg <= ovf_reg | acc_clamp;
                end
            end
        end
    end

    // Samples acc before a following vector's first beat can overwrite it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg  <= 1'b0;
            out_result_reg <= '0;
            out_ovf_reg    <= 1'b0;
        end else if (en) begin
            out_valid_reg <= s3_done_reg;
            if (s3_done_reg) begin
                out_result_reg <= conv_result;
                out_ovf_reg    <= ovf_reg | out_hi | out_lo;
            end
        end
    end

    assign bus.data_out   = s1_data_reg;
    assign bus.weight_out = s1_weight_reg;
    assign bus.fwd_valid  = s1_valid_reg;
    assign bus.fwd_first  = s1_first_reg;
    assign bus.fwd_last   = s1_last_reg;
    assign bus.out_valid  = out_valid_reg;
    assign bus.out_result = out_result_reg;
    assign bus.out_ovf    = out_ovf_reg;
endmodule

// File: doc/mac_pe_stream.md
Name: mac_pe_stream

Overview:
- Parametrised successor of the systolic fixed-point MAC processing element.
- Accumulates signed Qm.f dot-product vectors framed by first/last flags, with beat-level valid, global stall and a full-precision saturating accumulator.
- Emits a rounded, saturated result with an overflow flag once per vector.
- Forwards registered data, weight and framing to neighbouring PEs, so arrays can be chained with one-cycle skew.

Parameters:
- DATA_WIDTH, 12, signed input operand width (data and weight).
- FRAC_BITS, 6, fractional bits of the input and output format.
- ACC_WIDTH, 32, accumulator width; must be >= 2*DATA_WIDTH.
- OUT_WIDTH, 12, signed result width, with FRAC_BITS fractional bits.
- ROUND, 1: 1 = round-half-up on the output shift; 0 = truncate (floor).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- en  in  1  global enable; 0 freezes every register.
- in_valid  in  1  beat valid.
- in_first  in  1  first beat of a vector; meaningful only with in_valid.
- in_last  in  1  last beat of a vector; meaningful only with in_valid.
- data_in  in  DATA_WIDTH  signed activation.
- weight_in  in  DATA_WIDTH  signed weight.
- data_out  out  DATA_WIDTH  registered data_in, to the east neighbour.
- weight_out  out  DATA_WIDTH  registered weight_in, to the south neighbour.
- fwd_valid  out  1  registered in_valid.
- fwd_first  out  1  registered in_first.
- fwd_last  out  1  registered in_last.
- out_valid  out  1  result valid.
- out_result  out  OUT_WIDTH  signed rounded and saturated vector result.
- out_ovf  out  1  saturation occurred in this vector; qualified by out_valid.

Behaviour:
- Reset (asynchronous, at any time):
  - All pipeline registers, the accumulator and the sticky overflow clear to 0.
  - All outputs read 0.
  - A partially accumulated vector is discarded.
- en=0: all registers, including the forwarding and output registers, hold their values. out_valid stays at its current level, so consumers qualify it with en. en=1 advances the pipeline by one stage per edge.
- Pipeline (edge E0 samples the inputs):
  - S1 (E0): capture valid, first, last, data and weight. These registers drive data_out, weight_out and fwd_*, giving 1-cycle forwarding latency.
  - S2 (E1): full-precision signed product, 2*DATA_WIDTH bits with 2*FRAC_BITS fractional bits, sign-extended to ACC_WIDTH. Valid and framing are piped alongside.
  - S3 (E2): accumulator update, valid beats only. first=1 loads the product and clears the sticky ovf. first=0 adds the product to acc.
  - S4 (E3): if the S3 beat had last=1, register the result and pulse out_valid for one enabled cycle.
  - Result latency: E0 to out_valid visible after E3 (3 cycles after the sampling edge).
- Bubbles: an S2/S3 beat with valid=0 leaves acc and ovf unchanged. Vectors may contain gaps.
- Accumulator addition saturates to the signed ACC_WIDTH range (0x7FFFFFFF / 0x80000000 at default). Any clamp sets sticky ovf.
- Output conversion:
  - Shift: acc arithmetic-shift-right by FRAC_BITS. With ROUND=1, add 2^(FRAC_BITS-1) before the shift, using saturating addition.
  - Saturation: saturate to signed OUT_WIDTH. A clamp sets out_ovf for this result.
  - Reported flag: out_ovf = sticky ovf OR output clamp.
- first=1 and last=1 on the same beat form a one-beat vector: out_result = the converted product.
- first=1 arriving before the previous vector's last: the old accumulation is abandoned and no result is emitted for it.
- Valid beat with first=0 after reset: accumulates onto the reset value 0.
- Back-to-back vectors (last followed by first on the next beat) sustain one result per vector, with no dead cycle.
- out_result and out_ovf hold their last value while out_valid=0.

Test Plan:
- Scalar: first=last=1, data=0x040 (1.0), weight=0x060 (1.5), en=1 → 3 cycles later out_valid=1 for 1 cycle, out_result=0x060, out_ovf=0. data_out=0x040 and fwd_valid=1 appear 1 edge after sampling.
- Vector with bubble: beats (0x040,0x040,first), idle, (0x080,0x020), (0x020,0xFC0,last) → 1.0+1.0−0.5 → out_result=0x060, out_ovf=0. Exactly one out_valid pulse.
- Saturation: first=last=1 with 0x7FF×0x7FF → out_result=0x7FF, out_ovf=1. With 0x800×0x7FF → out_result=0x800, out_ovf=1. A following normal vector reports out_ovf=0.
- Rounding: 0x020×0x001 (product 32 LSB at 2f) → ROUND=1 gives 0x001; ROUND=0 gives 0x000.
- Stall: drop en for 5 cycles mid-vector and during the out_valid cycle → all outputs frozen; the result equals the unstalled value, and out_valid is counted once under en=1.
- Reset mid-vector: assert rst asynchronously (mid-cycle) after 2 beats → all outputs 0 immediately. After release, a new first/last beat 0x040×0x040 yields 0x040 with no residue.
